// File: rtl/gf_mul_mod_359_seq.sv
// Sequential GF(P) multiplier: r = a*b mod P using MSB-first shift/add/reduce over W cycles.
// Valid/ready handshakes on both sides. One operand pair is in flight at a time.
module gf_mul_mod_359_seq #(
  parameter int P = 359,
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din_a,
  input  logic [W-1:0] din_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout_r
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int TW = W + 2;
  localparam logic [W-1:0]  P_W     = W'(P);
  localparam logic [TW-1:0] P1_T    = TW'(P);
  localparam logic [TW-1:0] P2_T    = TW'(2 * P);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [W-1:0]  acc_reg, acc_next;
  logic [W-1:0]  dout_reg, dout_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  // Since 2**W < 2P, a single conditional subtract fully reduces the multiplicand.
  logic [W-1:0] a_red;
  assign a_red = (din_a >= P_W) ? (din_a - P_W) : din_a;

  logic         b_bit;
  logic [W-1:0] addend;
  assign b_bit = b_reg[cnt_reg];

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_addend
      assign addend[gi] = a_reg[gi] & b_bit;
    end
  endgenerate

  // t = 2*acc + addend stays below 3P, so at most one of the two subtracts applies.
  logic [TW-1:0] t_sum;
  logic [W-1:0]  step_res;
  assign t_sum = {1'b0, acc_reg, 1'b0} + {2'b00, addend};

  always_comb begin
    step_res = t_sum[W-1:0];
    if (t_sum >= P2_T) begin
      step_res = W'(t_sum - P2_T);
    end else if (t_sum >= P1_T) begin
      step_res = W'(t_sum - P1_T);
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = BUSY;
          a_next     = a_red;
          b_next     = din_b;
          acc_next   = '0;
          cnt_next   = CNT_TOP;
        end
      end
      BUSY: begin
        acc_next = step_res;
        if (cnt_reg == '0) begin
          dout_next  = step_res;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
    end
  end

  // Handshake outputs decode the state register only; no combinational path from out_ready.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign dout_r    = dout_reg;

endmodule

// File: tb/tb_gf_mul_mod_359_seq.sv
// Scoreboard bench for gf_mul_mod_359_seq: stimulus pushes expected residues,
// a monitor pops and compares on every out_valid&out_ready handshake.
module tb_gf_mul_mod_359_seq;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] din_a;
  logic [8:0] din_b;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] dout_r;

  gf_mul_mod_359_seq #(.P(359), .W(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .din_b     (din_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout_r    (dout_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int exp;
  } txn_t;

  txn_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ready_mode = 1;  // 0: random, 1: always ready, 2: hold off

  // Consumer side: out_ready driven on negedge according to ready_mode.
  always @(negedge clk) begin
    if (ready_mode == 1)      out_ready = 1'b1;
    else if (ready_mode == 2) out_ready = 1'b0;
    else                      out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: a handshake will occur at the next posedge when both are high here.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got dout_r=%0d with no pending operation", dout_r);
        end else begin
          txn_t t;
          t = sb.pop_front();
          if (int'(dout_r) != t.exp) begin
            failures++;
            $display("FAIL result a=%0d b=%0d: got %0d, expected %0d", t.a, t.b, dout_r, t.exp);
          end else begin
            $display("txn a=%0d b=%0d r=%0d ok", t.a, t.b, dout_r);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic send(input int a, input int b, input int exp);
    int c;
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("send_in_ready_wait", int'(in_ready), 1);
    din_a    = 9'(a);
    din_b    = 9'(b);
    in_valid = 1'b1;
    sb.push_back('{a, b, exp});
    @(negedge clk);
    in_valid = 1'b0;
    din_a    = 9'($urandom_range(0, 511));
    din_b    = 9'($urandom_range(0, 511));
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 600) begin
      @(negedge clk);
      c++;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: bench did not finish, pending=%0d", sb.size());
    $fatal(1, "timeout");
  end

  int da[6] = '{358, 200, 400, 511, 359, 3};
  int db[6] = '{358, 300, 2,   511, 1,   400};
  int de[6] = '{1,   47,  82,  128, 0,   123};

  initial begin
    int n;
    int c;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; din_a = '0; din_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_dout_r", int'(dout_r), 0);
    rst = 1'b0;

    // Zero multiplicand and exact latency from the accept edge.
    send(0, 123, 0);
    n = 1;
    @(posedge clk); #1;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency_edges", n, 9);
    drain();

    for (int i = 0; i < 6; i++) send(da[i], db[i], de[i]);
    drain();

    // Backpressure: result held stable while out_ready stays low.
    ready_mode = 2;
    send(200, 300, 47);
    c = 0;
    #2;
    while (!out_valid && c < 50) begin
      @(negedge clk); #2;
      c++;
    end
    check("bp_out_valid_seen", int'(out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #2;
      check("bp_hold_out_valid", int'(out_valid), 1);
      check("bp_hold_dout_r", int'(dout_r), 47);
      check("bp_hold_in_ready", int'(in_ready), 0);
    end
    ready_mode = 1;
    @(negedge clk); #2;
    check("bp_release_in_ready_same_cycle", int'(in_ready), 0);
    @(posedge clk); #1;
    check("bp_release_in_ready_next", int'(in_ready), 1);
    check("bp_release_out_valid", int'(out_valid), 0);
    drain();

    // Asynchronous reset in the middle of the iterations.
    send(5, 7, 35);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_dout_r", int'(dout_r), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale_valid", int'(seen), 0);
    send(2, 3, 6);
    drain();

    // Sweep with a randomly stalling consumer.
    ready_mode = 0;
    for (int a = 0; a < 359; a++) begin
      send(a, 1, a);
      send(a, 2, (a * 2) % 359);
      send(a, 358, (a * 358) % 359);
    end
    drain();
    ready_mode = 1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
